// File: rtl/vh_stim_misr.sv
// Stimulus counter plus 32-bit MISR compactor for expression-semantics test DUTs.
// Optional undef detection on the DUT response is enabled by defining VH_STIM_MISR_XCHECK_EN.
module vh_stim_misr #(
  parameter int          A_WIDTH     = 4,
  parameter int          Y_WIDTH     = 16,
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] POLY        = 32'h04C11DB7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [A_WIDTH-1:0] a,
  input  logic [Y_WIDTH-1:0] y,
  output logic               busy,
  output logic               done,
  output logic [31:0]        sig,
  output logic               x_seen
);

  localparam int IDX_W  = $clog2(NUM_VECTORS + 1);
  localparam int NCHUNK = (Y_WIDTH + 31) / 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n, idx_inc;
  logic [A_WIDTH-1:0]     a_n;
  logic [31:0]            sig_n;
  logic                   busy_n, done_n;
  logic                   accept_start;
  logic [NCHUNK*32-1:0]   y_ext;
  logic [31:0]            fold;

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  // Wide responses are zero-padded to whole 32-bit chunks and XOR-folded into one word.
  assign y_ext = (NCHUNK*32)'(y);

  always_comb begin
    fold = 32'h0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ y_ext[i*32 +: 32];
    end
  end

  assign idx_inc      = idx + IDX_W'(1);
  assign accept_start = start && (state == IDLE || state == DONE);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    a_n     = a;
    sig_n   = sig;
    busy_n  = busy;
    done_n  = done;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          idx_n   = '0;
          a_n     = '0;
          sig_n   = 32'h0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end
      end
      RUN: begin
        // The last vector is still absorbed; only idx and a stop advancing.
        sig_n = misr_step(sig, fold);
        if (idx == LAST_IDX) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n = idx_inc;
          a_n   = A_WIDTH'(idx_inc);
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a     <= '0;
      sig   <= 32'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      a     <= a_n;
      sig   <= sig_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

`ifdef VH_STIM_MISR_XCHECK_EN
  // Sticky per run: cleared only by reset or by the start that opens the next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_seen <= 1'b0;
    end else if (accept_start) begin
      x_seen <= 1'b0;
    end else if (state == RUN && ((^y) === 1'bx)) begin
      x_seen <= 1'b1;
    end
  end
`else
  assign x_seen = 1'b0;
`endif

endmodule

// File: tb/tb_vh_stim_misr.sv
// Directed self-checking bench for vh_stim_misr: default, two-vector/32-bit and single-vector/40-bit instances.
module tb_vh_stim_misr;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Default instance: y is either tied to zero or mirrors a.
  logic        start = 1'b0;
  logic        y_sel = 1'b0;
  logic [3:0]  a;
  logic [15:0] y;
  logic        busy, done, x_seen;
  logic [31:0] sig;

  // NUM_VECTORS=2, Y_WIDTH=32 instance.
  logic        start2 = 1'b0;
  logic [0:0]  a2;
  logic [31:0] y2 = 32'h0;
  logic        busy2, done2, x_seen2;
  logic [31:0] sig2;

  // NUM_VECTORS=1, Y_WIDTH=40 instance.
  logic        start3 = 1'b0;
  logic [3:0]  a3;
  logic [39:0] y3 = 40'h0;
  logic        busy3, done3, x_seen3;
  logic [31:0] sig3;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] COUNT_SIG = 32'h000008F7;

  always #5 clk = ~clk;

  always_comb y = y_sel ? {12'h000, a} : 16'h0000;

  vh_stim_misr dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .y(y),
    .busy(busy), .done(done), .sig(sig), .x_seen(x_seen)
  );

  vh_stim_misr #(.A_WIDTH(1), .Y_WIDTH(32), .NUM_VECTORS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .y(y2),
    .busy(busy2), .done(done2), .sig(sig2), .x_seen(x_seen2)
  );

  vh_stim_misr #(.A_WIDTH(4), .Y_WIDTH(40), .NUM_VECTORS(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .y(y3),
    .busy(busy3), .done(done3), .sig(sig3), .x_seen(x_seen3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (a !== 4'h0) begin fails++; $display("[TB] FAIL reset_a: got %h, expected 0", a); end
    checks++; if (sig !== 32'h0) begin fails++; $display("[TB] FAIL reset_sig: got %h, expected 0", sig); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    checks++; if (x_seen !== 1'b0) begin fails++; $display("[TB] FAIL reset_x_seen: got %b, expected 0", x_seen); end
    start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_holds_idle: got busy %b, expected 0", busy); end
    start = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL idle_hold: got busy %b done %b, expected 0 0", busy, done); end
  endtask

  task automatic test_zero_stimulus();
    y_sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || a !== 4'h0 || done !== 1'b0) begin fails++; $display("[TB] FAIL zero_first: got busy %b a %h done %b, expected 1 0 0", busy, a, done); end
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++; if (a !== 4'(k) || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("[TB] FAIL zero_step%0d: got a %h busy %b done %b, expected %h 1 0", k, a, busy, done, 4'(k)); end
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_done: got done %b busy %b, expected 1 0", done, busy); end
    checks++; if (sig !== 32'h0) begin fails++; $display("[TB] FAIL zero_sig: got %h, expected 0", sig); end
    checks++; if (a !== 4'hF) begin fails++; $display("[TB] FAIL zero_a_hold: got %h, expected f", a); end
    tick();
    checks++; if (done !== 1'b1 || sig !== 32'h0) begin fails++; $display("[TB] FAIL zero_done_hold: got done %b sig %h, expected 1 0", done, sig); end
  endtask

  task automatic test_counting_pattern();
    int n;
    y_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1 || sig !== 32'h0) begin fails++; $display("[TB] FAIL count_restart: got done %b busy %b sig %h, expected 0 1 0", done, busy, sig); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n !== 16) begin fails++; $display("[TB] FAIL count_len: got %0d edges, expected 16", n); end
    checks++; if (sig !== COUNT_SIG) begin fails++; $display("[TB] FAIL count_sig: got %h, expected %h", sig, COUNT_SIG); end
    checks++; if (x_seen !== 1'b0) begin fails++; $display("[TB] FAIL count_x_seen: got %b, expected 0", x_seen); end
  endtask

  task automatic test_start_ignored();
    int n;
    y_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      start = (n == 4);
      tick();
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 16) begin fails++; $display("[TB] FAIL ignore_len: got %0d edges, expected 16", n); end
    checks++; if (sig !== COUNT_SIG) begin fails++; $display("[TB] FAIL ignore_sig: got %h, expected %h", sig, COUNT_SIG); end
  endtask

  task automatic test_reset_midrun();
    int n;
    y_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++; if (a !== 4'h7 || busy !== 1'b1) begin fails++; $display("[TB] FAIL midrun_pre: got a %h busy %b, expected 7 1", a, busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (a !== 4'h0 || sig !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL midrun_reset: got a %h sig %h busy %b done %b, expected 0 0 0 0", a, sig, busy, done); end
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n !== 16) begin fails++; $display("[TB] FAIL midrun_len: got %0d edges, expected 16", n); end
    checks++; if (sig !== COUNT_SIG) begin fails++; $display("[TB] FAIL midrun_sig: got %h, expected %h", sig, COUNT_SIG); end
  endtask

  task automatic test_back_to_back();
    int n;
    y_sel = 1'b1;
    start = 1'b1;
    tick();
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n !== 16 || sig !== COUNT_SIG) begin fails++; $display("[TB] FAIL b2b_first: got %0d edges sig %h, expected 16 %h", n, sig, COUNT_SIG); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b1 || a !== 4'h0 || sig !== 32'h0) begin fails++; $display("[TB] FAIL b2b_restart: got done %b busy %b a %h sig %h, expected 0 1 0 0", done, busy, a, sig); end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n !== 16 || sig !== COUNT_SIG) begin fails++; $display("[TB] FAIL b2b_second: got %0d edges sig %h, expected 16 %h", n, sig, COUNT_SIG); end
  endtask

  task automatic test_two_vectors();
    y2 = 32'h00000001;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++; if (busy2 !== 1'b1 || sig2 !== 32'h0 || a2 !== 1'b0) begin fails++; $display("[TB] FAIL two_start: got busy %b sig %h a %b, expected 1 0 0", busy2, sig2, a2); end
    tick();
    checks++; if (sig2 !== 32'h1 || a2 !== 1'b1 || done2 !== 1'b0) begin fails++; $display("[TB] FAIL two_first: got sig %h a %b done %b, expected 1 1 0", sig2, a2, done2); end
    tick();
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b0 || sig2 !== 32'h3 || a2 !== 1'b1) begin fails++; $display("[TB] FAIL two_done: got done %b busy %b sig %h a %b, expected 1 0 3 1", done2, busy2, sig2, a2); end
    y2 = 32'h80000000;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    checks++; if (sig2 !== 32'h80000000) begin fails++; $display("[TB] FAIL poly_first: got %h, expected 80000000", sig2); end
    tick();
    checks++; if (sig2 !== 32'h84C11DB7 || done2 !== 1'b1) begin fails++; $display("[TB] FAIL poly_feedback: got sig %h done %b, expected 84c11db7 1", sig2, done2); end
  endtask

  task automatic test_wide_fold();
    y3 = 40'h01_0000_0000;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    checks++; if (busy3 !== 1'b1 || done3 !== 1'b0) begin fails++; $display("[TB] FAIL wide_start: got busy %b done %b, expected 1 0", busy3, done3); end
    tick();
    checks++; if (done3 !== 1'b1 || busy3 !== 1'b0 || sig3 !== 32'h1) begin fails++; $display("[TB] FAIL wide_upper: got done %b busy %b sig %h, expected 1 0 1", done3, busy3, sig3); end
    y3 = 40'hFF_0000_00F0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    checks++; if (sig3 !== 32'h0 || done3 !== 1'b0) begin fails++; $display("[TB] FAIL wide_restart: got sig %h done %b, expected 0 0", sig3, done3); end
    tick();
    checks++; if (sig3 !== 32'h0000000F || a3 !== 4'h0) begin fails++; $display("[TB] FAIL wide_xor: got sig %h a %h, expected f 0", sig3, a3); end
  endtask

  initial begin
    test_reset();
    test_zero_stimulus();
    test_counting_pattern();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_two_vectors();
    test_wide_fold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
